multicycle_conunit: RTL
=======================

// Module: multicycle_conunit
// PURPOSE
//  Multi-cycle MIPS control FSM with exception/interrupt sequencing; next generation of the single-cycle decoder.
//  Same ISA and datapath strobes (add,sub,and,or,addi,andi,ori,lw,sw,beq,bne,j), plus eret and a memory ready handshake.
//  Adds precise traps: reserved instruction, optional overflow, and IRQ_N external interrupts. Sits between IR/flags and the datapath.
// PARAMETERS
//  IRQ_N    4  number of external interrupt lines (1..8)
//  IRQ_PRIO 0  0: lowest-index pending line wins; 1: highest-index wins
// PORTS
//  Clk      in  1      clock, rising edge
//  Reset    in  1      synchronous, active-high
//  Op       in  6      IR[31:26]
//  Func     in  6      IR[5:0]
//  Z        in  1      ALU zero flag
//  V        in  1      ALU signed-overflow flag (EXE cycle)
//  Irq      in  IRQ_N  level interrupt requests
//  Ie       in  1      global interrupt enable (status register)
//  Mrdy     in  1      memory ready; completes the current Mreq transaction
//  Mreq     out 1      memory request (IF fetch / MEM data access)
//  Iord     out 1      0: address=PC, 1: address=ALU result
//  Wir      out 1      IR load
//  Wpc      out 1      PC load
//  Pcsrc    out 3      000 PC+4, 010 branch target, 011 jump, 100 EPC, 101 exception vector
//  Regrt, Se, Aluqb, Reg2reg, Aluc[1:0]  out  decode fields, same encoding as single-cycle unit
//  Wreg     out 1      register file write
//  Wmem     out 1      data memory write (qualified by Mreq)
//  Wepc     out 1      EPC load;  Epcsel out 1: 0 EPC<=PC, 1 EPC<=PC-4
//  Wcause   out 1      Cause load; Cause out 5: 0 Int, 10 RI, 12 Ov
//  Irq_ack  out IRQ_N  one-hot acknowledge of serviced line
//  State    out 3      current state (debug)
// BEHAVIOUR
//  States: IF=0 ID=1 EXE=2 MEM=3 WB=4 EXC=5; codes 6,7 -> IF next cycle, all strobes 0.
//  Reset: State<=IF; irq index/cause regs <=0; while Reset=1 all write strobes
//   (Wir,Wpc,Wreg,Wmem,Wepc,Wcause,Mreq) and Irq_ack forced 0. Reset mid-transaction aborts it.
//  IF: if Ie & |Irq -> capture winner index and Cause=0, go EXC, no Mreq. Else Mreq=1,Iord=0;
//   stay while !Mrdy; Mrdy cycle: Wir=1,Wpc=1,Pcsrc=000 -> ID.
//  ID: undefined Op/Func -> EXC Cause=10 Epcsel=1. j: Wpc,Pcsrc=011 -> IF.
//   eret (Op=010000,Func=011000): Wpc,Pcsrc=100 -> IF. Others -> EXE.
//  EXE: beq/bne: Wpc,Pcsrc=010 only if taken (beq&Z | bne&~Z) -> IF. lw/sw -> MEM.
//   ALU ops -> WB, except trap case (CONFIGURATION) -> EXC Cause=12 Epcsel=1.
//  MEM: Mreq=1,Iord=1, Wmem=1 for sw; hold all while !Mrdy. Mrdy: sw -> IF, lw -> WB.
//  WB: Wreg=1 (Reg2reg=0 for lw) -> IF.
//  EXC: one cycle: Wepc=1,Wcause=1,Wpc=1,Pcsrc=101; Irq_ack one-hot iff Cause=0 -> IF.
//  Interrupts sampled only in IF (instruction boundary); faults preempt: no Wreg/Wmem for faulting instr.
//  Cycle counts (Mrdy=1): j/eret 2, branch 3, ALU 4, sw 4, lw 5, trap entry +1.
//  Decode outputs combinational from Op/Func; strobes combinational from State/inputs.
// CONFIGURATION
//  OVF_TRAP_EN defined: add, sub, addi with V=1 in EXE -> EXC Cause=12, no Wreg.
//  Undefined: V ignored, result written back; Cause 12 never produced.
// TESTING
//  Reset 3 cycles mid-MEM of sw -> State=0, Wmem=0, Mreq=0 during reset; fetch resumes.
//  add with Mrdy low 2 cycles in IF -> Wir pulses once on Mrdy; Wreg in cycle 6 after first Mreq.
//  beq Z=1 -> Wpc,Pcsrc=010 in EXE; beq Z=0 -> Wpc=0, back to IF, 3 cycles.
//  Op=111111 -> EXC Cause=10 Epcsel=1 Wepc=Wcause=1 Pcsrc=101, no Wreg.
//  Irq=4'b0110,Ie=1 in IF, IRQ_PRIO=0 -> EXC, Irq_ack=4'b0010, Cause=0, Epcsel=0; Ie=0 -> ignored.
//  OVF_TRAP_EN: addi V=1 -> Cause=12 trap; without macro -> Wreg=1, no trap.

Source files
------------

// File: rtl/multicycle_conunit.sv
// Multi-cycle MIPS control FSM with precise traps, eret and IRQ_N prioritised interrupts.
// Optional overflow trap on add/sub/addi is enabled by defining OVF_TRAP_EN.
module multicycle_conunit #(
    parameter int unsigned IRQ_N    = 4,
    parameter int unsigned IRQ_PRIO = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Z,
    input  logic             V,
    input  logic [IRQ_N-1:0] Irq,
    input  logic             Ie,
    input  logic             Mrdy,
    output logic             Mreq,
    output logic             Iord,
    output logic             Wir,
    output logic             Wpc,
    output logic [2:0]       Pcsrc,
    output logic             Regrt,
    output logic             Se,
    output logic             Aluqb,
    output logic             Reg2reg,
    output logic [1:0]       Aluc,
    output logic             Wreg,
    output logic             Wmem,
    output logic             Wepc,
    output logic             Epcsel,
    output logic             Wcause,
    output logic [4:0]       Cause,
    output logic [IRQ_N-1:0] Irq_ack,
    output logic [2:0]       State
);

    localparam int unsigned IdxW     = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
    localparam logic [4:0]  CauseInt = 5'd0;
    localparam logic [4:0]  CauseRi  = 5'd10;
    localparam logic [4:0]  CauseOv  = 5'd12;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4,
        StExc = 3'd5
    } state_e;

    state_e            r_state;
    logic [4:0]        r_cause;
    logic [IdxW-1:0]   r_irq_idx;

    logic w_rtype, w_add, w_sub, w_and, w_or, w_addi, w_andi, w_ori;
    logic w_lw, w_sw, w_beq, w_bne, w_j, w_eret;
    logic w_alu_r, w_alu, w_branch, w_mem, w_valid, w_taken, w_ovf, w_irq_take;
    logic [IdxW-1:0] w_irq_idx;

    assign w_rtype  = (Op == 6'b000000);
    assign w_add    = w_rtype & (Func == 6'b100000);
    assign w_sub    = w_rtype & (Func == 6'b100010);
    assign w_and    = w_rtype & (Func == 6'b100100);
    assign w_or     = w_rtype & (Func == 6'b100101);
    assign w_addi   = (Op == 6'b001000);
    assign w_andi   = (Op == 6'b001100);
    assign w_ori    = (Op == 6'b001101);
    assign w_lw     = (Op == 6'b100011);
    assign w_sw     = (Op == 6'b101011);
    assign w_beq    = (Op == 6'b000100);
    assign w_bne    = (Op == 6'b000101);
    assign w_j      = (Op == 6'b000010);
    assign w_eret   = (Op == 6'b010000) & (Func == 6'b011000);
    assign w_alu_r  = w_add | w_sub | w_and | w_or;
    assign w_alu    = w_alu_r | w_addi | w_andi | w_ori;
    assign w_branch = w_beq | w_bne;
    assign w_mem    = w_lw | w_sw;
    assign w_valid  = w_alu | w_branch | w_mem | w_j | w_eret;
    assign w_taken  = (w_beq & Z) | (w_bne & ~Z);

`ifdef OVF_TRAP_EN
    assign w_ovf = (w_add | w_sub | w_addi) & V;
`else
    logic w_unused_v;
    assign w_unused_v = V;
    assign w_ovf      = 1'b0;
`endif

    // Decode fields: Aluc 00 add, 01 sub, 10 and, 11 or.
    assign Regrt   = w_addi | w_andi | w_ori | w_lw;
    assign Se      = w_addi | w_lw | w_sw | w_beq | w_bne;
    assign Aluqb   = w_alu_r | w_branch;
    assign Reg2reg = ~w_lw;
    assign Aluc    = {w_and | w_andi | w_or | w_ori, w_sub | w_branch | w_or | w_ori};

    assign w_irq_take = Ie & (|Irq);

    // Later loop assignments win, so loop direction sets the priority.
    always_comb begin
        w_irq_idx = '0;
        if (IRQ_PRIO == 0) begin
            for (int i = int'(IRQ_N) - 1; i >= 0; i--) begin
                if (Irq[i]) w_irq_idx = IdxW'(i);
            end
        end else begin
            for (int i = 0; i < int'(IRQ_N); i++) begin
                if (Irq[i]) w_irq_idx = IdxW'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= StIf;
            r_cause   <= '0;
            r_irq_idx <= '0;
        end else begin
            case (r_state)
                StIf: begin
                    if (w_irq_take) begin
                        r_state   <= StExc;
                        r_cause   <= CauseInt;
                        r_irq_idx <= w_irq_idx;
                    end else if (Mrdy) begin
                        r_state <= StId;
                    end
                end
                StId: begin
                    if (!w_valid) begin
                        r_state <= StExc;
                        r_cause <= CauseRi;
                    end else if (w_j | w_eret) begin
                        r_state <= StIf;
                    end else begin
                        r_state <= StExe;
                    end
                end
                StExe: begin
                    if (w_branch) begin
                        r_state <= StIf;
                    end else if (w_mem) begin
                        r_state <= StMem;
                    end else if (w_ovf) begin
                        r_state <= StExc;
                        r_cause <= CauseOv;
                    end else begin
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (Mrdy) r_state <= w_sw ? StIf : StWb;
                end
                StWb:    r_state <= StIf;
                StExc:   r_state <= StIf;
                default: r_state <= StIf;
            endcase
        end
    end

    always_comb begin
        Mreq    = 1'b0;
        Iord    = 1'b0;
        Wir     = 1'b0;
        Wpc     = 1'b0;
        Pcsrc   = 3'b000;
        Wreg    = 1'b0;
        Wmem    = 1'b0;
        Wepc    = 1'b0;
        Epcsel  = 1'b0;
        Wcause  = 1'b0;
        Irq_ack = '0;
        case (r_state)
            StIf: begin
                if (!w_irq_take) begin
                    Mreq = 1'b1;
                    Wir  = Mrdy;
                    Wpc  = Mrdy;
                end
            end
            StId: begin
                if (w_valid && w_j) begin
                    Wpc   = 1'b1;
                    Pcsrc = 3'b011;
                end else if (w_valid && w_eret) begin
                    Wpc   = 1'b1;
                    Pcsrc = 3'b100;
                end
            end
            StExe: begin
                if (w_branch && w_taken) begin
                    Wpc   = 1'b1;
                    Pcsrc = 3'b010;
                end
            end
            StMem: begin
                Mreq = 1'b1;
                Iord = 1'b1;
                Wmem = w_sw;
            end
            StWb: Wreg = 1'b1;
            StExc: begin
                Wepc   = 1'b1;
                Wcause = 1'b1;
                Wpc    = 1'b1;
                Pcsrc  = 3'b101;
                // Faults point EPC back at the faulting instruction; interrupts resume at PC.
                Epcsel = (r_cause != CauseInt);
                if (r_cause == CauseInt) Irq_ack[r_irq_idx] = 1'b1;
            end
            default: ;
        endcase
        if (Reset) begin
            Mreq    = 1'b0;
            Wir     = 1'b0;
            Wpc     = 1'b0;
            Wreg    = 1'b0;
            Wmem    = 1'b0;
            Wepc    = 1'b0;
            Wcause  = 1'b0;
            Irq_ack = '0;
        end
    end

    assign Cause = r_cause;
    assign State = r_state;

endmodule
